// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - bus-mapped UART transmit FIFO and launch sequencer for uart_tx
// Optional transmit-done interrupt built only when UART_TX_CTRL_IRQ_EN is defined.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy
`ifdef UART_TX_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            overflow_q;
  logic            enable_q;
  logic            irq_en;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic [31:0]     rdata_q, rdata_d;

  logic            empty, full, busy;
  logic            wr_txdata, wr_ctrl;
  logic            pop, push;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign busy      = (state_q != IDLE) | tx_busy;
  assign wr_txdata = bus_wr && (bus_addr == ADDR_TXDATA);
  assign wr_ctrl   = bus_wr && (bus_addr == ADDR_CTRL);
  // A pop in the same cycle frees the slot the write needs.
  assign push      = wr_txdata && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_q && !empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= pop;
      if (pop) begin
        tx_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // The set wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (wr_txdata && full && !pop) begin
      overflow_q <= 1'b1;
    end else if (wr_ctrl && bus_wdata[2]) begin
      overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable_q <= 1'b1;
    end else if (wr_ctrl) begin
      enable_q <= bus_wdata[0];
    end
  end

`ifdef UART_TX_CTRL_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en_q <= bus_wdata[1];
      end
      irq_q <= irq_en_q && empty && (state_q == IDLE) && !tx_busy;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;

  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[31:8];
`else
  assign irq_en = 1'b0;

  logic unused_wdata;
  assign unused_wdata = ^{bus_wdata[31:8], bus_wdata[1]};
`endif

  always_comb begin
    rdata_d = 32'h0;
    case (bus_addr)
      ADDR_STATUS: rdata_d = {16'h0, 8'(level_q), 4'h0, overflow_q, full, empty, busy};
      ADDR_CTRL:   rdata_d = {29'h0, 1'b0, irq_en, enable_q};
      default:     rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
    end else if (bus_rd) begin
      rdata_q <= rdata_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl with a behavioural uart_tx
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
`ifdef UART_TX_CTRL_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy)
`ifdef UART_TX_CTRL_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  // Serializer stand-in: samples tx_start when idle, one bit per clock.
  logic       tx_line;
  logic [9:0] sh;
  int         cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_line <= 1'b1;
      cnt     <= 0;
      sh      <= 10'h3ff;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        sh      <= {1'b1, tx_data, 1'b0};
        cnt     <= 10;
      end
    end else begin
      tx_line <= sh[0];
      sh      <= sh >> 1;
      cnt     <= cnt - 1;
      if (cnt == 1) begin
        tx_busy <= 1'b0;
        tx_line <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every launch must match the next expected byte, last one cycle, and find uart_tx idle.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_launch", {24'h0, tx_data}, 32'hffff_ffff);
      end else begin
        chk("launch_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
      chk("start_one_cycle", {31'h0, prev_start}, 32'h0);
      chk("start_while_idle", {31'h0, tx_busy}, 32'h0);
    end
    prev_start = rst_n && tx_start;
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus_rd = 1'b1; bus_addr = a;
    @(negedge clk);
    bus_rd = 1'b0;
    d = bus_rdata;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int n;
    n = 0;
    s = 32'h1;
    while (((s & 32'h3) != 32'h2) && n < 2000) begin
      rd(4'h4, s);
      n++;
    end
    if ((s & 32'h3) != 32'h2) chk(name, s, 32'h2);
  endtask

  initial begin
    logic [31:0] r;
    int p0;
    logic ok;

    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
`ifdef UART_TX_CTRL_IRQ_EN
    chk("rst_irq", {31'h0, irq}, 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    rd(4'h4, r); chk("reset_status", r, 32'h0000_0002);
    rd(4'h8, r); chk("reset_ctrl", r, 32'h0000_0001);
    rd(4'hc, r); chk("bad_addr_read", r, 32'h0);
    wr(4'hc, 32'hff);
    rd(4'h4, r); chk("bad_addr_write", r, 32'h0000_0002);

    // Write-to-launch latency: start high exactly E1..E2.
    exp_q.push_back(8'h41);
    wr(4'h0, 32'h41);
    chk("launch_e0", {31'h0, tx_start}, 32'h0);
    @(negedge clk);
    chk("launch_e1", {31'h0, tx_start}, 32'h1);
    chk("launch_e1_data", {24'h0, tx_data}, 32'h41);
    @(negedge clk);
    chk("launch_e2", {31'h0, tx_start}, 32'h0);
    wait_idle("idle_after_41");

    // Fill while disabled, overflow, clear, then write+pop while full.
    wr(4'h8, 32'h0);
    for (int i = 0; i < 16; i++) wr(4'h0, 32'h30 + i);
    wr(4'h0, 32'h40);
    rd(4'h4, r); chk("full_overflow_status", r, 32'h0000_100c);
    wr(4'h8, 32'h4);
    rd(4'h4, r); chk("overflow_cleared", r, 32'h0000_1004);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h30 + 8'(i));
    exp_q.push_back(8'h50);
    p0 = pulses;
    wr(4'h8, 32'h1);
    wr(4'h0, 32'h50);
    rd(4'h4, r); chk("write_pop_full", r, 32'h0000_1005);
    wait_idle("idle_after_fill");
    chk("fill_pulses", pulses - p0, 17);
    rd(4'h4, r); chk("drained_status", r, 32'h0000_0002);

    // Disabled queue holds bytes; re-enable drains them.
    wr(4'h8, 32'h0);
    p0 = pulses;
    for (int i = 0; i < 3; i++) wr(4'h0, 32'h61 + i);
    repeat (30) @(negedge clk);
    chk("disabled_no_launch", pulses - p0, 0);
    rd(4'h4, r); chk("disabled_level3", r, 32'h0000_0300);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h61 + 8'(i));
    wr(4'h8, 32'h1);
    wait_idle("idle_after_enable");
    chk("enable_pulses", pulses - p0, 3);

    // Reset during a frame with bytes queued.
    wr(4'h8, 32'h0);
    for (int i = 0; i < 5; i++) wr(4'h0, 32'h71 + i);
    exp_q.push_back(8'h71);
    wr(4'h8, 32'h1);
    repeat (5) @(negedge clk);
    chk("frame_in_flight", {31'h0, tx_busy}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || tx_line !== 1'b1) ok = 1'b0;
    end
    chk("reset_quiet_line", {31'h0, ok}, 32'h1);
    rd(4'h4, r); chk("reset_mid_status", r, 32'h0000_0002);

    wr(4'h8, 32'h3);
    rd(4'h8, r);
`ifdef UART_TX_CTRL_IRQ_EN
    chk("ctrl_irq_en", r, 32'h3);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h82);
    wr(4'h0, 32'h81);
    wr(4'h0, 32'h82);
    repeat (6) @(negedge clk);
    chk("irq_low_busy", {31'h0, irq}, 32'h0);
    wait_idle("idle_irq");
    @(negedge clk);
    chk("irq_high_done", {31'h0, irq}, 32'h1);
    exp_q.push_back(8'h83);
    wr(4'h0, 32'h83);
    chk("irq_after_e0", {31'h0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_cleared_by_write", {31'h0, irq}, 32'h0);
    wait_idle("idle_irq2");
`else
    chk("ctrl_bit1_absent", r, 32'h1);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
